// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Types and constants shared by the layer training blocks and the network
// controller.
//   NN_DATA_W      : width of data_type (signed Q8.8)
//   data_type      : signed fixed-point data word
//   DATA_MAX       : most positive data_type value
//   DATA_MIN       : most negative data_type value
//   train_state_t  : training-step sequencer states. The encoding is visible
//                    on the debug port and is decoded by the controller.
// -----------------------------------------------------------------------------
package nn_pkg;

  localparam int NN_DATA_W = 16;

  typedef logic signed [NN_DATA_W-1:0] data_type;

  localparam data_type DATA_MAX = {1'b0, {(NN_DATA_W-1){1'b1}}};
  localparam data_type DATA_MIN = {1'b1, {(NN_DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FWD       = 3'd1,
    ST_WAIT_GRAD = 3'd2,
    ST_BWD       = 3'd3,
    ST_UPD       = 3'd4,
    ST_DONE      = 3'd5
  } train_state_t;

endpackage

// File: rtl/sat_sub_shift.sv
// -----------------------------------------------------------------------------
// sat_sub_shift
// Purely combinational parameter-update element:
//   result = sat(w - (grad >>> shift))
// The shift is arithmetic, so a negative gradient stays negative. The
// subtraction is done one bit wider than the data, so any overflow shows up as
// a disagreement between the top two bits. The result is then clamped to
// [DATA_MIN, DATA_MAX]. The bias-update path uses the same element.
// Ports:
//   w      in  NN_DATA_W  current parameter value
//   grad   in  NN_DATA_W  gradient for that parameter
//   shift  in  LR_W       learning rate as a right-shift amount
//   result out NN_DATA_W  saturated updated value
// -----------------------------------------------------------------------------
module sat_sub_shift
  import nn_pkg::*;
#(
  parameter int LR_W = 4
) (
  input  logic [NN_DATA_W-1:0] w,
  input  logic [NN_DATA_W-1:0] grad,
  input  logic [LR_W-1:0]      shift,
  output logic [NN_DATA_W-1:0] result
);

  logic signed [NN_DATA_W-1:0] step;
  logic signed [NN_DATA_W:0]   diff;

  assign step = $signed(grad) >>> shift;
  assign diff = $signed({w[NN_DATA_W-1], w}) - $signed({step[NN_DATA_W-1], step});

  always_comb begin
    result = diff[NN_DATA_W-1:0];
    // If the top two bits differ, the true result does not fit in NN_DATA_W.
    // The extra top bit then gives the true sign, which picks the rail.
    if (diff[NN_DATA_W] != diff[NN_DATA_W-1]) begin
      result = diff[NN_DATA_W] ? DATA_MIN : DATA_MAX;
    end
  end

endmodule

// File: rtl/neuron_train_sequencer.sv
// -----------------------------------------------------------------------------
// neuron_train_sequencer
// Runs one training step of an M x N neuron layer:
//   forward pass -> wait for gradient -> backward pass -> weight update.
// The layer pipelines have fixed latency and no valid signals. Capture strobes
// are therefore placed by counting cycles from the start of each pass. The
// update walks W in row-major order, one element per cycle, and writes
//   W <= sat(W - (dw >>> lr_q)).
// The weight file provides w_rd/dw_rd combinationally at the current address.
// Ports:
//   clk, reset   clock; synchronous active-high reset
//   start        one-cycle step request, accepted only in IDLE
//   lr_shift     learning-rate shift, captured when start is accepted
//   grad_valid   upstream gradient is stable (sampled in WAIT_GRAD)
//   w_rd, dw_rd  W and dw at (upd_row, upd_col)
//   busy         high in any state other than IDLE
//   done         one-cycle pulse at the end of the step
//   fwd_capture  strobe: latch a and z
//   bwd_capture  strobe: latch da, db and dw
//   upd_we       weight write enable (high for the whole UPD state)
//   upd_row/col  update address; zero outside UPD
//   w_wr         updated weight; zero outside UPD
//   state_o      current state encoding, for debug
// -----------------------------------------------------------------------------
module neuron_train_sequencer
  import nn_pkg::*;
#(
  parameter int M       = 5,
  parameter int N       = 3,
  parameter int FWD_LAT = 3,
  parameter int BWD_LAT = 2,
  parameter int DATA_W  = NN_DATA_W,
  parameter int LR_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LR_W-1:0]      lr_shift,
  input  logic                 grad_valid,
  input  logic [DATA_W-1:0]    w_rd,
  input  logic [DATA_W-1:0]    dw_rd,
  output logic                 busy,
  output logic                 done,
  output logic                 fwd_capture,
  output logic                 bwd_capture,
  output logic                 upd_we,
  output logic [$clog2(M)-1:0] upd_row,
  output logic [$clog2(N)-1:0] upd_col,
  output logic [DATA_W-1:0]    w_wr,
  output logic [2:0]           state_o
);

  localparam int ROW_W   = $clog2(M);
  localparam int COL_W   = $clog2(N);
  localparam int CNT_MAX = (FWD_LAT > BWD_LAT) ? FWD_LAT : BWD_LAT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] FWD_LAST = CNT_W'(FWD_LAT - 1);
  localparam logic [CNT_W-1:0] BWD_LAST = CNT_W'(BWD_LAT - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(M - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N - 1);

  train_state_t     state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
  logic [ROW_W-1:0] row_reg,   row_next;
  logic [COL_W-1:0] col_reg,   col_next;
  logic [LR_W-1:0]  lr_reg,    lr_next;

  logic [DATA_W-1:0] upd_value;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      row_reg   <= '0;
      col_reg   <= '0;
      lr_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      lr_reg    <= lr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and strobe logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    row_next    = row_reg;
    col_next    = col_reg;
    lr_next     = lr_reg;
    fwd_capture = 1'b0;
    bwd_capture = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FWD;
          lr_next    = lr_shift;
          cnt_next   = '0;
        end
      end

      // cnt counts cycles spent in FWD. The forward result is valid in the
      // FWD_LAT-th cycle, which is the last cycle in this state.
      ST_FWD: begin
        if (cnt_reg == FWD_LAST) begin
          fwd_capture = 1'b1;
          state_next  = ST_WAIT_GRAD;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      ST_WAIT_GRAD: begin
        if (grad_valid) begin
          state_next = ST_BWD;
          cnt_next   = '0;
        end
      end

      ST_BWD: begin
        if (cnt_reg == BWD_LAST) begin
          bwd_capture = 1'b1;
          state_next  = ST_UPD;
          cnt_next    = '0;
          row_next    = '0;
          col_next    = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      // One write per cycle, in row-major order. The column advances first and
      // the row advances when the column wraps.
      ST_UPD: begin
        if (col_reg == COL_LAST) begin
          col_next = '0;
          if (row_reg == ROW_LAST) begin
            row_next   = '0;
            state_next = ST_DONE;
          end else begin
            row_next = row_reg + ROW_W'(1);
          end
        end else begin
          col_next = col_reg + COL_W'(1);
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        row_next   = '0;
        col_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Update datapath: combinational from the current address
  // ---------------------------------------------------------------------------
  sat_sub_shift #(
    .LR_W (LR_W)
  ) u_sat_sub_shift (
    .w      (w_rd),
    .grad   (dw_rd),
    .shift  (lr_reg),
    .result (upd_value)
  );

  // ---------------------------------------------------------------------------
  // Outputs. Address and data are forced to zero outside UPD, so the weight
  // file never sees stale values.
  // ---------------------------------------------------------------------------
  assign busy    = (state_reg != ST_IDLE);
  assign done    = (state_reg == ST_DONE);
  assign upd_we  = (state_reg == ST_UPD);
  assign upd_row = upd_we ? row_reg : '0;
  assign upd_col = upd_we ? col_reg : '0;
  assign w_wr    = upd_we ? upd_value : '0;
  assign state_o = state_reg;

endmodule

// File: tb/tb_neuron_train_sequencer.sv
// -----------------------------------------------------------------------------
// tb_neuron_train_sequencer
// Scoreboard bench. Each issued step pushes its expected event stream into
// exp_q. An event is a capture, a write or done, and each one carries the cycle
// at which it must appear. A negedge monitor pops and compares every event the
// DUT presents. W and dw come from fixed tables, and the expected update
// values in those tables were worked out by hand.
// -----------------------------------------------------------------------------
module tb_neuron_train_sequencer;

  localparam int M = 5;
  localparam int N = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  lr_shift;
  logic        grad_valid;
  logic [15:0] w_rd;
  logic [15:0] dw_rd;
  logic        busy;
  logic        done;
  logic        fwd_capture;
  logic        bwd_capture;
  logic        upd_we;
  logic [2:0]  upd_row;
  logic [1:0]  upd_col;
  logic [15:0] w_wr;
  logic [2:0]  state_o;

  neuron_train_sequencer #(
    .M (M), .N (N), .FWD_LAT (3), .BWD_LAT (2), .DATA_W (16), .LR_W (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .lr_shift    (lr_shift),
    .grad_valid  (grad_valid),
    .w_rd        (w_rd),
    .dw_rd       (dw_rd),
    .busy        (busy),
    .done        (done),
    .fwd_capture (fwd_capture),
    .bwd_capture (bwd_capture),
    .upd_we      (upd_we),
    .upd_row     (upd_row),
    .upd_col     (upd_col),
    .w_wr        (w_wr),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand tables indexed by row*3+col, plus the expected results for
  // lr_shift=0 (EXP0) and lr_shift=2 (EXP2), worked out by hand.
  localparam logic [15:0] W_TAB [15] = '{
    16'h0100, 16'h7F00, 16'h8100, 16'h0000, 16'h1234,
    16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF, 16'h0200,
    16'hFE00, 16'h4000, 16'h0001, 16'hC000, 16'h00FF};
  localparam logic [15:0] DW_TAB [15] = '{
    16'hFF00, 16'h8000, 16'h7FFF, 16'h0000, 16'h0010,
    16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0100,
    16'hFC00, 16'hC000, 16'h0003, 16'h4001, 16'hFFF9};
  localparam logic [15:0] EXP0 [15] = '{
    16'h0200, 16'h7FFF, 16'h8000, 16'h0000, 16'h1224,
    16'hFFFE, 16'h0001, 16'h8000, 16'h7FFF, 16'h0100,
    16'h0200, 16'h7FFF, 16'hFFFE, 16'h8000, 16'h0106};
  localparam logic [15:0] EXP2 [15] = '{
    16'h0140, 16'h7FFF, 16'h8000, 16'h0000, 16'h1230,
    16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF, 16'h01C0,
    16'hFF00, 16'h5000, 16'h0001, 16'hB000, 16'h0101};

  always_comb begin
    int idx;
    idx = int'(upd_row) * N + int'(upd_col);
    w_rd  = 16'h0;
    dw_rd = 16'h0;
    if (idx < 15) begin
      w_rd  = W_TAB[idx];
      dw_rd = DW_TAB[idx];
    end
  end

  typedef struct {
    int          kind;   // 0 fwd_capture, 1 bwd_capture, 2 write, 3 done
    int          cyc;
    int          row;
    int          col;
    logic [15:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  cyc      = 0;
  int  checks   = 0;
  int  errors   = 0;
  int  wr_seen  = 0;
  int  done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kind_name(int k);
    case (k)
      0:       return "fwd_capture";
      1:       return "bwd_capture";
      2:       return "write";
      default: return "done";
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Pop and compare one DUT event against the scoreboard.
  task automatic check_ev(input int kind, input int row, input int col, input logic [15:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got cyc=%0d row=%0d col=%0d data=%h expected no event",
               kind_name(kind), cyc, row, col, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc ||
          (kind == 2 && (e.row != row || e.col != col || e.data != data))) begin
        errors++;
        $display("FAIL %s: got %s cyc=%0d row=%0d col=%0d data=%h expected %s cyc=%0d row=%0d col=%0d data=%h",
                 kind_name(e.kind), kind_name(kind), cyc, row, col, data,
                 kind_name(e.kind), e.cyc, e.row, e.col, e.data);
      end else begin
        $display("cyc=%0d %s row=%0d col=%0d data=%h ok", cyc, kind_name(kind), row, col, data);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (fwd_capture) check_ev(0, 0, 0, 16'h0);
    if (bwd_capture) check_ev(1, 0, 0, 16'h0);
    if (upd_we) begin
      check_ev(2, int'(upd_row), int'(upd_col), w_wr);
      wr_seen++;
    end
    if (done) begin
      check_ev(3, 0, 0, 16'h0);
      done_cnt++;
    end
    if (!upd_we) begin
      checks++;
      if (upd_row != 0 || upd_col != 0 || w_wr != 0) begin
        errors++;
        $display("FAIL idle_outputs: got row=%0d col=%0d w_wr=%h expected all zero (cyc %0d)",
                 upd_row, upd_col, w_wr, cyc);
      end
    end
  end

  // Expected event stream for a step whose start is sampled at the edge that
  // begins cycle s, with w cycles spent in WAIT_GRAD.
  function automatic void push_step(input int s, input int w, input logic [3:0] lr);
    ev_t e;
    e.row = 0; e.col = 0; e.data = 16'h0;
    e.kind = 0; e.cyc = s + 2;     exp_q.push_back(e);
    e.kind = 1; e.cyc = s + 4 + w; exp_q.push_back(e);
    for (int k = 0; k < 15; k++) begin
      e.kind = 2;
      e.cyc  = s + 5 + w + k;
      e.row  = k / N;
      e.col  = k % N;
      e.data = (lr == 4'd0) ? EXP0[k] : EXP2[k];
      exp_q.push_back(e);
    end
    e.kind = 3; e.cyc = s + 20 + w; e.row = 0; e.col = 0; e.data = 16'h0;
    exp_q.push_back(e);
  endfunction

  // Must be called 1 time unit after a rising edge; returns the same way.
  task automatic run_step(input logic [3:0] lr, input int w, input bit pulse);
    int s;
    int d0;
    bit ok;
    d0 = done_cnt;
    wr_seen = 0;
    start = 1'b1;
    lr_shift = lr;
    grad_valid = (w == 1);
    s = cyc + 1;
    push_step(s, w, lr);
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(posedge clk);
      #1;
      start = pulse && (cyc == s + 3 + w || cyc == s + w + 10);
      if (cyc >= s + 2 + w) grad_valid = 1'b1;
      if (cyc >= s + 3 && cyc <= s + 2 + w) begin
        chk("wait_state", int'(state_o), 2);
        chk("wait_busy", int'(busy), 1);
      end
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    grad_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_timeout: got no done pulse expected one within 400 cycles");
    end
    chk("step_queue_empty", exp_q.size(), 0);
    chk("step_end_state", int'(state_o), 0);
    chk("step_end_busy", int'(busy), 0);
    chk("step_writes", wr_seen, 15);
    exp_q.delete();
  endtask

  task automatic reset_mid_upd();
    int s;
    int t;
    wr_seen = 0;
    start = 1'b1;
    lr_shift = 4'd0;
    grad_valid = 1'b1;
    s = cyc + 1;
    push_step(s, 1, 4'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    t = 0;
    while (wr_seen < 7 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("writes_before_reset", wr_seen, 7);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    chk("rst_mid_state", int'(state_o), 0);
    chk("rst_mid_upd_we", int'(upd_we), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_w_wr", int'(w_wr), 0);
    reset = 1'b0;
    grad_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_stays_idle", int'(state_o), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    lr_shift = 4'd0;
    grad_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", int'(state_o), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_fwd_capture", int'(fwd_capture), 0);
    chk("reset_bwd_capture", int'(bwd_capture), 0);
    chk("reset_upd_we", int'(upd_we), 0);
    chk("reset_w_wr", int'(w_wr), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Nominal step, lr_shift=0, grad_valid held high: done 22 cycles in.
    run_step(4'd0, 1, 1'b0);
    // Gradient held off for 10 cycles, lr_shift=2.
    run_step(4'd2, 10, 1'b0);
    // Stray start pulses during BWD and UPD must be ignored.
    run_step(4'd0, 1, 1'b1);
    // Reset during the update, then a complete step.
    reset_mid_upd();
    run_step(4'd2, 1, 1'b0);

    // Simultaneous start and reset: the step must not start.
    reset = 1'b1;
    start = 1'b1;
    lr_shift = 4'd2;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    chk("start_reset_state", int'(state_o), 0);
    chk("start_reset_busy", int'(busy), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("start_reset_idle", int'(state_o), 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_train_sequencer.md
Name: neuron_train_sequencer

Overview:
- Sequences one training step of an M-neuron layer built from forward_neurons and backward_neurons: forward pass, gradient wait, backward pass, then an element-serial weight update W <= W - (dw >>> lr_shift).
- Sits between the network-level controller (start/done handshake) and the layer datapath plus its weight register file.
- The layer pipelines have fixed latency, so capture points are fixed by counting cycles. The datapath has no valid signals.

Parameters:
- M, 5, neuron count (rows of W)
- N, 3, inputs per neuron (columns of W)
- FWD_LAT, 3, cycles from x stable to a valid (mult, bias and relu registers)
- BWD_LAT, 2, cycles from da_prev stable to da/db/dw valid
- DATA_W, 16, width of data_type (signed Q8.8)
- LR_W, 4, width of lr_shift

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin a training step
- lr_shift  in  LR_W  learning rate as right-shift amount; sampled on accepted start
- grad_valid  in  1  upstream da_prev is stable
- w_rd  in  DATA_W  W[upd_row][upd_col], combinational read
- dw_rd  in  DATA_W  dw[upd_row][upd_col], combinational read
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at the end of the step
- fwd_capture  out  1  one-cycle strobe: latch a and z
- bwd_capture  out  1  one-cycle strobe: latch da, db and dw
- upd_we  out  1  weight write enable
- upd_row  out  $clog2(M)  update row address
- upd_col  out  $clog2(N)  update column address
- w_wr  out  DATA_W  new weight value
- state_o  out  3  current state, for debug

Behaviour:
- Reset: sync active-high. On the next edge: state IDLE, all counters 0, lr_q=0, and busy, done, fwd_capture, bwd_capture, upd_we, upd_row, upd_col, w_wr all 0. Reset wins over every other input and aborts any operation in progress without issuing further writes.
- States: IDLE=0, FWD=1, WAIT_GRAD=2, BWD=3, UPD=4, DONE=5.
- IDLE: start=1 -> FWD, lr_q<=lr_shift, cnt<=0. start is ignored in every other state; no queuing.
- FWD: cnt increments each cycle. When cnt==FWD_LAT-1, assert fwd_capture for that cycle and go to WAIT_GRAD. This gives FWD_LAT cycles in FWD.
- WAIT_GRAD: hold indefinitely until grad_valid=1, then go to BWD with cnt<=0. If grad_valid is already high on the entry cycle, it is still sampled on the following edge, so the minimum time in this state is 1 cycle.
- BWD: same counting as FWD with BWD_LAT. bwd_capture pulses on the last BWD cycle. Next state UPD with row=col=0.
- UPD: upd_we=1 for every cycle in this state.
  - Address order is row-major: col increments first and wraps N-1 -> 0 with row+1.
  - After row=M-1, col=N-1 is written, go to DONE. Exactly M*N writes, one per cycle, no gaps.
- DONE: done=1 for one cycle, then IDLE. busy is high through DONE and low in IDLE.
- Update arithmetic:
  - step = dw_rd >>> lr_q (arithmetic shift).
  - diff = w_rd - step, computed at DATA_W+1 bits.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. lr_q=0 means full-gradient step.
  - w_wr is combinational from the current address. The write commits on the edge at which upd_we=1.
- Outputs upd_row, upd_col and w_wr are 0 outside UPD.
- Total step latency from start edge to done pulse: FWD_LAT + wait + BWD_LAT + M*N + 1 cycles, where wait >= 1.
- Simultaneous start and reset: reset wins and the step is not started.

Decomposition:
- Shared package nn_pkg: data_type (DATA_W signed), DATA_MAX and DATA_MIN constants, and a state enum typedef used by this block and by the network controller.
- One sub-module: sat_sub_shift. Purely combinational; implements shift, subtract and saturate, and is reusable by the bias-update path.

Test Plan:
1. Reset mid-UPD at write 7 -> next cycle state_o=0, upd_we=0, busy=0; a new start then runs a full 15-write step.
2. start with M=5, N=3, lr_shift=0, grad_valid held high -> fwd_capture at cycle 3, bwd_capture at cycle 6, 15 writes with addresses (0,0)…(4,2) in row-major order, done pulse at cycle 22.
3. grad_valid held low 10 cycles after FWD -> state_o=2 for 10 cycles, no captures or writes; BWD starts the cycle after grad_valid rises.
4. w_rd=0x0100, dw_rd=0xFF00, lr_shift=2 -> w_wr=0x0140 (1.0 - (-1.0/4) = 1.25).
5. w_rd=0x7F00, dw_rd=0x8000, lr_shift=0 -> w_wr=0x7FFF (positive saturation); w_rd=0x8100, dw_rd=0x7FFF -> w_wr=0x8000.
6. start pulsed during BWD and UPD -> ignored: exactly one done pulse and 15 writes.
